// File: rtl/if_stage.sv
// Instruction fetch stage: issues SRAM reads, holds the fetched word for ID,
// and redirects on branches from ID while keeping the delay slot intact.
module if_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_allow_in,
  input  logic [32:0] id_to_if_branch_bus,
  output logic [64:0] if_to_id_instruction_bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  logic        w_toIfValid;
  logic        w_ifReadyGo;
  logic        w_ifAllowIn;
  logic        w_branchTaken;
  logic [31:0] w_branchTarget;
  logic [31:0] w_nextPc;
  logic [31:0] w_instruction;

  logic        r_ifValid;
  logic [31:0] r_ifPc;
  logic        r_pendingValid;
  logic [31:0] r_pendingTarget;
  logic [31:0] r_instBuffer;
  logic        r_instBufferValid;

  assign w_branchTaken  = id_to_if_branch_bus[32];
  assign w_branchTarget = id_to_if_branch_bus[31:0];

  assign w_toIfValid = !reset;
  assign w_ifReadyGo = 1'b1;
  assign w_ifAllowIn = !r_ifValid || (w_ifReadyGo && id_allow_in);

  // A branch that arrived while fetch was blocked outranks any later branch_taken.
  always_comb begin
    if (r_pendingValid) begin
      w_nextPc = r_pendingTarget;
    end else if (w_branchTaken) begin
      w_nextPc = w_branchTarget;
    end else begin
      w_nextPc = r_ifPc + 32'd4;
    end
  end

  assign inst_sram_en    = w_toIfValid && w_ifAllowIn;
  assign inst_sram_addr  = w_nextPc;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_wdata = 32'h0000_0000;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ifValid <= 1'b0;
      r_ifPc    <= RESET_VECTOR - 32'd4;
    end else if (w_ifAllowIn) begin
      r_ifValid <= w_toIfValid;
      r_ifPc    <= w_nextPc;
    end
  end

  // Remember a branch that could not be fetched yet; it is used by the next request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pendingValid  <= 1'b0;
      r_pendingTarget <= 32'h0000_0000;
    end else if (r_pendingValid) begin
      if (inst_sram_en) begin
        r_pendingValid <= 1'b0;
      end
    end else if (w_branchTaken && !inst_sram_en) begin
      r_pendingValid  <= 1'b1;
      r_pendingTarget <= w_branchTarget;
    end
  end

  // SRAM data is only valid for one cycle, so a stalled instruction is parked here.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_instBuffer      <= 32'h0000_0000;
      r_instBufferValid <= 1'b0;
    end else if (w_ifAllowIn && r_ifValid) begin
      r_instBufferValid <= 1'b0;
    end else if (r_ifValid && !r_instBufferValid && !id_allow_in) begin
      r_instBuffer      <= inst_sram_rdata;
      r_instBufferValid <= 1'b1;
    end
  end

  assign w_instruction = r_instBufferValid ? r_instBuffer : inst_sram_rdata;

  assign if_to_id_instruction_bus = {r_ifValid && w_ifReadyGo, r_ifPc, w_instruction};

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: a behavioural fetch model feeds a scoreboard
// that a negedge monitor drains whenever ID accepts an instruction.
module tb_if_stage;

  localparam logic [31:0] RV = 32'hBFC00000;

  logic        clock;
  logic        reset;
  logic        idAllowIn;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic [64:0] instBus;
  logic        sramEn;
  logic [3:0]  sramWen;
  logic [31:0] sramAddr;
  logic [31:0] sramWdata;
  logic [31:0] sramRdata;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetchT;

  fetchT       expQ[$];
  int          testsRun = 0;
  int          testsFailed = 0;
  int          deliveries = 0;
  logic        mPend = 1'b0;
  logic [31:0] mPendTgt = 32'h0;
  logic [31:0] mLastPc = RV - 32'd4;

  if_stage #(.RESET_VECTOR(RV)) dut (
    .clock                    (clock),
    .reset                    (reset),
    .id_allow_in              (idAllowIn),
    .id_to_if_branch_bus      ({branchTaken, branchTarget}),
    .if_to_id_instruction_bus (instBus),
    .inst_sram_en             (sramEn),
    .inst_sram_wen            (sramWen),
    .inst_sram_addr           (sramAddr),
    .inst_sram_wdata          (sramWdata),
    .inst_sram_rdata          (sramRdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h24010001;
  endfunction

  // Instruction SRAM: one-cycle read latency, garbage whenever no read was issued.
  always @(posedge clock) begin
    if (sramEn) sramRdata <= memWord(sramAddr);
    else        sramRdata <= $urandom;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: IF holds at most one instruction; a fetch happens whenever it is empty
  // (the monitor empties it on acceptance), going to a remembered branch, a fresh branch, or pc+4.
  initial begin
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        expQ.delete();
        mPend   = 1'b0;
        mLastPc = RV - 32'd4;
      end else if (clock) begin
        if (expQ.size() == 0) begin
          fetchT f;
          if (mPend)            f.pc = mPendTgt;
          else if (branchTaken) f.pc = branchTarget;
          else                  f.pc = mLastPc + 32'd4;
          f.instr = memWord(f.pc);
          expQ.push_back(f);
          mLastPc = f.pc;
          mPend   = 1'b0;
        end else if (branchTaken && !mPend) begin
          mPend    = 1'b1;
          mPendTgt = branchTarget;
        end
      end
    end
  end

  // Monitor: checks occupancy and request enable every cycle, and pops on each delivery.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        checkOutput("rst_en", {31'b0, sramEn}, 32'd0);
        checkOutput("rst_valid", {31'b0, instBus[64]}, 32'd0);
      end else begin
        checkOutput("bus_valid", {31'b0, instBus[64]}, {31'b0, expQ.size() != 0});
        checkOutput("sram_en", {31'b0, sramEn}, {31'b0, (expQ.size() == 0) || idAllowIn});
        if (instBus[64] && idAllowIn) begin
          if (expQ.size() == 0) begin
            checkOutput("deliver_unexpected", instBus[63:32], 32'hFFFFFFFF);
          end else begin
            fetchT e;
            e = expQ.pop_front();
            checkOutput("deliver_pc", instBus[63:32], e.pc);
            checkOutput("deliver_instr", instBus[31:0], e.instr);
            deliveries++;
          end
        end
      end
    end
  end

  task automatic applyStimulus(input int cycles, input int allowPct, input int branchPct);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock);
      #1;
      idAllowIn    = ($urandom_range(0, 99) < allowPct);
      branchTaken  = ($urandom_range(0, 99) < branchPct);
      branchTarget = {RV[31:16], 16'($urandom_range(0, 65535)) & 16'hFFFC};
    end
  endtask

  initial begin
    reset        = 1'b1;
    idAllowIn    = 1'b0;
    branchTaken  = 1'b0;
    branchTarget = 32'h0;
    repeat (3) @(posedge clock);
    #2;
    checkOutput("reset_wen", {28'b0, sramWen}, 32'd0);
    checkOutput("reset_wdata", sramWdata, 32'd0);
    checkOutput("reset_en", {31'b0, sramEn}, 32'd0);

    @(posedge clock);
    #1;
    reset     = 1'b0;
    idAllowIn = 1'b1;
    #1;
    checkOutput("first_addr", sramAddr, RV);
    checkOutput("first_en", {31'b0, sramEn}, 32'd1);
    @(posedge clock);
    #1;
    checkOutput("second_addr", sramAddr, RV + 32'd4);
    checkOutput("first_pc", instBus[63:32], RV);

    applyStimulus(20, 100, 0);
    applyStimulus(400, 65, 12);
    applyStimulus(100, 30, 25);

    // Reset raised between edges mid-stream must drop the outputs immediately.
    @(posedge clock);
    idAllowIn = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    checkOutput("midrst_en", {31'b0, sramEn}, 32'd0);
    checkOutput("midrst_valid", {31'b0, instBus[64]}, 32'd0);
    @(posedge clock);
    #1;
    reset       = 1'b0;
    branchTaken = 1'b0;
    #1;
    checkOutput("midrst_restart_addr", sramAddr, RV);

    applyStimulus(200, 65, 12);
    @(posedge clock);
    #1;
    idAllowIn   = 1'b1;
    branchTaken = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("delivery_count_ok", {31'b0, deliveries >= 250}, 32'd1);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
